// File: rtl/sipo.sv
// Serial-in parallel-out deserializer feeding a transparent word latch.
// Collects WIDTH bits per word and emits the word with a one-cycle le pulse.
module sipo #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdi,
  input  logic             sdi_en,
  input  logic             clr,
  output logic [WIDTH-1:0] data,
  output logic             le,
  output logic [CW-1:0]    count,
  output logic             busy
);

  logic [WIDTH-1:0] sr_q,    sr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             le_q,    le_d;
  logic [WIDTH-1:0] sr_next_s;
  logic             last_s;

  // Shift direction decides which end of the word the first bit ends up in.
  always_comb begin
    if (MSB_FIRST) begin
      sr_next_s = {sr_q[WIDTH-2:0], sdi};
    end else begin
      sr_next_s = {sdi, sr_q[WIDTH-1:1]};
    end
    last_s = (count_q == CW'(WIDTH - 1));
  end

  // Next-state logic: clr beats sdi_en; le only rises on a word-complete edge.
  always_comb begin
    sr_d    = sr_q;
    count_d = count_q;
    data_d  = data_q;
    le_d    = 1'b0;
    if (clr) begin
      sr_d    = {WIDTH{1'b0}};
      count_d = {CW{1'b0}};
    end else if (sdi_en) begin
      sr_d = sr_next_s;
      if (last_s) begin
        count_d = {CW{1'b0}};
        data_d  = sr_next_s;
        le_d    = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      sr_d    = sr_q;
      count_d = count_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q    <= {WIDTH{1'b0}};
      count_q <= {CW{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      le_q    <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      count_q <= count_d;
      data_q  <= data_d;
      le_q    <= le_d;
    end
  end

  assign data  = data_q;
  assign le    = le_q;
  assign count = count_q;
  assign busy  = (count_q != {CW{1'b0}});

endmodule

// File: doc/sipo.md
# sipo

Serial-in parallel-out deserializer that sits directly upstream of the `pipo` latch. It shifts in one bit per enabled clock. When a full word has arrived, it presents the word on `data` and pulses `le` for one cycle, so the downstream latch captures the word while `le` is high. Its outputs connect straight to the latch's `in` and `le` inputs.

## Interface
- `WIDTH`, default 8: word width in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `data[WIDTH-1]`; 0 means it lands in `data[0]`.
- `CW`, default `$clog2(WIDTH)`: width of the bit counter. Derived; do not override.

- `clk`  input  1  single clock; every register updates on its rising edge.
- `rst_n`  input  1  reset, synchronous and active-low; sampled on the `clk` rising edge.
- `sdi`  input  1  serial data bit.
- `sdi_en`  input  1  bit strobe; `sdi` is consumed on each rising edge where `sdi_en`=1.
- `clr`  input  1  synchronous abort; discards any partial word.
- `data`  output  WIDTH  last complete word, registered; feeds latch `in`.
- `le`  output  1  one-cycle word-complete pulse, registered; feeds latch `le`.
- `count`  output  CW  number of bits of the current partial word received so far (0..WIDTH-1).
- `busy`  output  1  high when `count`≠0, i.e. a partial word is pending; combinational from `count`.

## Operation
- Internal state: shift register `sr[WIDTH-1:0]` and counter `count`.
- Two logical states, both derived from `count` (no separate state register):
  - IDLE: `count`=0.
  - SHIFT: `count` in 1..WIDTH-1.
- Priority on each rising edge, highest first:
  1. `rst_n`=0
  2. `clr`=1
  3. `sdi_en`=1
  4. hold
- On reset:
  - `sr`=0, `count`=0, `data`=0, `le`=0.
- On `clr`=1 (with `rst_n`=1):
  - `sr`=0, `count`=0, `le`=0.
  - `data` keeps its last complete word.
  - `sdi` is ignored in that cycle.
- On `sdi_en`=1, shift:
  - `MSB_FIRST`=1: `sr_next` = {`sr[WIDTH-2:0]`, `sdi`}.
  - `MSB_FIRST`=0: `sr_next` = {`sdi`, `sr[WIDTH-1:1]`}.
- Bit that is not the last of the word (`count`<WIDTH-1):
  - `sr` ← `sr_next`; `count` ← `count`+1; `le` ← 0.
- Last bit of the word (`count`=WIDTH-1):
  - `data` ← `sr_next`; `le` ← 1; `count` ← 0 (wraps to IDLE).
  - `sr` ← `sr_next`; this content is don't-care because the next word fully overwrites it.
- Any cycle that does not complete a word drives `le` ← 0. `le` is therefore never high for two consecutive cycles.
- `data` changes only on a word-complete edge or on reset. It is stable at all other times, including during `clr`.
- There is no backpressure. The downstream latch is transparent while `le` is high, so the one-cycle pulse is sufficient.

## Timing
- Latency: `le` and the new `data` both become visible in the cycle immediately after the rising edge that samples the final bit.
- `data` is valid for the whole `le`-high cycle and holds until the next word completes.
- Back-to-back words with `sdi_en` held high: `le` pulses exactly every WIDTH cycles. The first bit of the next word may be sampled on the same edge that raises `le`; no dead cycle is needed.
- Gaps in `sdi_en` stretch a word arbitrarily without losing bits; `count` holds during the gaps.
- `clr` on the same edge as the final bit: `clr` wins. No `le` pulse, `data` is unchanged, and the bit is lost.
- Reset mid-word: the partial word is discarded, `data`=0 and `le`=0 from the next cycle. A subsequent word starts at `count`=0.
- `count` is always in 0..WIDTH-1; it never reaches WIDTH.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `sdi_en`=1 and `sdi`=1 → `data`=0x00, `le`=0, `count`=0 and `busy`=0 throughout and after release.
- MSB-first word (`WIDTH`=8): shift the bits 0,1,0,1,0,1,0,1 on consecutive cycles → `le`=1 for exactly one cycle, starting the cycle after the 8th bit; `data`=0x55; `count` returns to 0.
- Back-to-back words: 0x55 then 0xAA, `sdi_en` high for 16 consecutive cycles → two `le` pulses exactly 8 cycles apart. `data`=0x55 during the first pulse and 0xAA during the second; no extra pulses.
- Gapped strobe: send 0xA5 with `sdi_en` low for 3 cycles between every pair of bits → a single `le` pulse after the 8th strobe; `data`=0xA5; `count` holds steady during the gaps.
- Abort: with `data`=0x55 held, send 5 bits of 1, then `clr`=1 → `count`=0 and `data` stays 0x55. Then send 0x3C → `data`=0x3C with exactly one `le` pulse. Separately, assert `clr` on the edge of the 8th bit → no `le` pulse and `data` unchanged.
- LSB-first (`MSB_FIRST`=0): shift the bits 1,0,0,0,0,0,0,0 → `data`=0x01. Then assert `rst_n`=0 after 4 bits of the next word → `data`=0x00, `le`=0, `count`=0.
